key_conditioner: RTL and testbench

Front-end stage that drives the digital lock's key_a..key_d inputs.
- Takes four raw, asynchronous push-button levels and synchronises and debounces each one.
- Each accepted press becomes exactly one single-cycle, one-hot pulse on key_a..key_d.
- Simultaneous presses are rejected and flagged on key_err, so the lock's sequence FSM only ever sees clean, single key events.

---
 rtl/key_pkg.sv | 14 +
 rtl/key_debounce.sv | 36 +++
 rtl/key_conditioner.sv | 84 ++++++++
 tb/tb_key_conditioner.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: key codes, FSM state encoding and rise-vector helpers for key_conditioner
package key_pkg;
  localparam logic [1:0] KEY_A = 2'd0;
  localparam logic [1:0] KEY_B = 2'd1;
  localparam logic [1:0] KEY_C = 2'd2;
  localparam logic [1:0] KEY_D = 2'd3;
  typedef enum logic {ST_IDLE, ST_HELD} state_e;
  function automatic logic [2:0] count_rise(input logic [3:0] r);
    return 3'(r[0]) + 3'(r[1]) + 3'(r[2]) + 3'(r[3]);
  endfunction
  function automatic logic [1:0] encode_key(input logic [3:0] r);
    return r[0] ? KEY_A : r[1] ? KEY_B : r[2] ? KEY_C : KEY_D;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise one raw button and emit a debounced level plus a rise strobe
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, rise_q, sample, differ, expire;
  assign sample = sync_q[SYNC_STAGES-1];
  assign differ = sample != level_q;
  // the level flips on the edge the counter sits at its last value while the sample still differs
  assign expire = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_comb cnt_d = (!differ || expire) ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q   <= cnt_d;
      level_q <= level_q ^ expire;
      rise_q  <= expire && !level_q;
    end
  end
  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounce four buttons and emit clean single-cycle one-hot key events
module key_conditioner
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_c,
  input  logic       raw_d,
  output logic       key_a,
  output logic       key_b,
  output logic       key_c,
  output logic       key_d,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic       key_err,
  output logic       busy
);
  logic [3:0] raw_v, level_v, rise_v, keys_q;
  logic [2:0] n_rise;
  logic [1:0] code_d, code_q;
  logic valid_q, err_q, busy_q;
  state_e state_q;
  assign raw_v = {raw_d, raw_c, raw_b, raw_a};
  for (genvar i = 0; i < 4; i++) begin : g_deb
    key_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_deb (
      .clk(clk),
      .reset(reset),
      .raw(raw_v[i]),
      .level(level_v[i]),
      .rise(rise_v[i])
    );
  end
  always_comb begin
    n_rise = count_rise(rise_v);
    code_d = encode_key(rise_v);
  end
  // rises seen while HELD, including the exit cycle, are dropped so each press needs a fresh rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      keys_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= KEY_A;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      keys_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= KEY_A;
      err_q   <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (n_rise == 3'd1) begin
          keys_q  <= rise_v;
          valid_q <= 1'b1;
          code_q  <= code_d;
          state_q <= ST_HELD;
          busy_q  <= 1'b1;
        end else if (n_rise > 3'd1) begin
          err_q   <= 1'b1;
          state_q <= ST_HELD;
          busy_q  <= 1'b1;
        end
      end else if (level_v == 4'b0000) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end
  assign {key_d, key_c, key_b, key_a} = keys_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_err   = err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios for key_conditioner with hand-computed cycle stamps
module tb_key_conditioner;
  logic clk = 1'b0, reset = 1'b0;
  logic raw_a = 1'b0, raw_b = 1'b0, raw_c = 1'b0, raw_d = 1'b0;
  logic key_a, key_b, key_c, key_d, key_valid, key_err, busy;
  logic [1:0] key_code;
  int cyc = 0, total = 0, bad = 0, proto_bad = 0, busy_hi = 0;
  int ev_code[$], ev_cyc[$], err_cyc[$];

  key_conditioner dut (
    .clk(clk), .reset(reset),
    .raw_a(raw_a), .raw_b(raw_b), .raw_c(raw_c), .raw_d(raw_d),
    .key_a(key_a), .key_b(key_b), .key_c(key_c), .key_d(key_d),
    .key_valid(key_valid), .key_code(key_code), .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc seen here equals the number of rising edges so far
  always @(negedge clk) begin
    if (key_valid) begin
      ev_code.push_back(int'(key_code));
      ev_cyc.push_back(cyc);
    end
    if (key_err) err_cyc.push_back(cyc);
    if (busy) busy_hi++;
    if ({key_d, key_c, key_b, key_a} !== (key_valid ? (4'b0001 << key_code) : 4'b0000) ||
        (!key_valid && key_code !== 2'd0)) proto_bad++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log;
    ev_code.delete();
    ev_cyc.delete();
    err_cyc.delete();
    busy_hi = 0;
  endtask

  task automatic set_key(input int code, input logic v);
    case (code)
      0: raw_a = v;
      1: raw_b = v;
      2: raw_c = v;
      default: raw_d = v;
    endcase
  endtask

  task automatic test_reset;
    step(3);
    total++;
    if ({key_a, key_b, key_c, key_d, key_valid, key_err, busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000000", {key_a, key_b, key_c, key_d, key_valid, key_err, busy});
    end
    total++;
    if (key_code !== 2'd0) begin
      bad++;
      $display("FAIL reset_code: got %0d want 0", key_code);
    end
    raw_a = 1'b1;
    step(10);
    total++;
    if ({key_a, key_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_held_press: got %b want 000", {key_a, key_valid, busy});
    end
    raw_a = 1'b0;
    step(2);
    reset = 1'b1;
    step(10);
    clear_log();
  endtask

  task automatic test_single_press;
    int c;
    clear_log();
    c = cyc;
    raw_a = 1'b1;
    step(6);
    total++;
    if (key_a !== 1'b0) begin
      bad++;
      $display("FAIL single_early: got key_a=%b want 0", key_a);
    end
    step(1);
    total++;
    if ({key_a, key_valid, key_code, busy} !== 5'b11001) begin
      bad++;
      $display("FAIL single_pulse: got %b want 11001", {key_a, key_valid, key_code, busy});
    end
    step(1);
    total++;
    if ({key_a, key_valid} !== 2'b00) begin
      bad++;
      $display("FAIL single_width: got %b want 00", {key_a, key_valid});
    end
    step(12);
    raw_a = 1'b0;
    step(6);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_hold: got %b want 1", busy);
    end
    step(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_drop: got %b want 0", busy);
    end
    total++;
    if (ev_cyc.size() != 1 || ev_cyc[0] != c + 7) begin
      bad++;
      $display("FAIL single_events: got n=%0d want n=1 at cycle %0d", ev_cyc.size(), c + 7);
    end
    step(5);
  endtask

  task automatic test_bounce;
    clear_log();
    for (int i = 0; i < 10; i++) begin
      raw_c = ~raw_c;
      step(1);
    end
    raw_c = 1'b0;
    step(15);
    total++;
    if (ev_code.size() != 0 || err_cyc.size() != 0) begin
      bad++;
      $display("FAIL bounce_events: got keys=%0d errs=%0d want 0 0", ev_code.size(), err_cyc.size());
    end
    total++;
    if (busy_hi != 0) begin
      bad++;
      $display("FAIL bounce_busy: got %0d busy cycles want 0", busy_hi);
    end
  endtask

  task automatic test_sequence;
    int c0, got_code, got_cyc;
    int codes[6] = '{0, 2, 0, 1, 2, 3};
    clear_log();
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      set_key(codes[k], 1'b1);
      step(10);
      set_key(codes[k], 1'b0);
      step(10);
    end
    step(10);
    total++;
    if (ev_code.size() != 6) begin
      bad++;
      $display("FAIL seq_count: got %0d want 6", ev_code.size());
    end
    for (int k = 0; k < 6; k++) begin
      got_code = k < ev_code.size() ? ev_code[k] : -1;
      got_cyc  = k < ev_cyc.size() ? ev_cyc[k] : -1;
      total++;
      if (got_code != codes[k] || got_cyc != c0 + 20 * k + 7) begin
        bad++;
        $display("FAIL seq_key%0d: got code=%0d cycle=%0d want code=%0d cycle=%0d",
                 k, got_code, got_cyc, codes[k], c0 + 20 * k + 7);
      end
    end
    total++;
    if (err_cyc.size() != 0) begin
      bad++;
      $display("FAIL seq_err: got %0d errors want 0", err_cyc.size());
    end
  endtask

  task automatic test_simultaneous;
    int c, c2;
    clear_log();
    c = cyc;
    raw_b = 1'b1;
    raw_d = 1'b1;
    step(10);
    raw_b = 1'b0;
    raw_d = 1'b0;
    step(20);
    total++;
    if (err_cyc.size() != 1 || err_cyc[0] != c + 7) begin
      bad++;
      $display("FAIL simul_err: got n=%0d want n=1 at cycle %0d", err_cyc.size(), c + 7);
    end
    total++;
    if (ev_code.size() != 0) begin
      bad++;
      $display("FAIL simul_nokey: got %0d keys want 0", ev_code.size());
    end
    c2 = cyc;
    raw_a = 1'b1;
    step(10);
    raw_a = 1'b0;
    step(20);
    total++;
    if (ev_code.size() != 1 || ev_code[0] != 0 || ev_cyc[0] != c2 + 7) begin
      bad++;
      $display("FAIL simul_recover: got n=%0d want key A at cycle %0d", ev_code.size(), c2 + 7);
    end
    total++;
    if (err_cyc.size() != 1) begin
      bad++;
      $display("FAIL simul_err_once: got %0d want 1", err_cyc.size());
    end
  endtask

  task automatic test_press_during_hold;
    int c;
    clear_log();
    c = cyc;
    raw_a = 1'b1;
    step(10);
    raw_b = 1'b1;
    step(20);
    raw_a = 1'b0;
    raw_b = 1'b0;
    step(10);
    raw_b = 1'b1;
    step(10);
    raw_b = 1'b0;
    step(20);
    total++;
    if (ev_code.size() != 2) begin
      bad++;
      $display("FAIL hold_count: got %0d want 2", ev_code.size());
    end else begin
      total++;
      if (ev_code[0] != 0 || ev_cyc[0] != c + 7) begin
        bad++;
        $display("FAIL hold_first: got code=%0d cycle=%0d want 0 at %0d", ev_code[0], ev_cyc[0], c + 7);
      end
      total++;
      if (ev_code[1] != 1 || ev_cyc[1] != c + 47) begin
        bad++;
        $display("FAIL hold_second: got code=%0d cycle=%0d want 1 at %0d", ev_code[1], ev_cyc[1], c + 47);
      end
    end
    total++;
    if (err_cyc.size() != 0) begin
      bad++;
      $display("FAIL hold_err: got %0d want 0", err_cyc.size());
    end
  endtask

  task automatic test_reset_mid_hold;
    int c;
    clear_log();
    c = cyc;
    raw_d = 1'b1;
    step(8);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({key_a, key_b, key_c, key_d, key_valid, key_code, key_err, busy} !== 9'b0) begin
        bad++;
        $display("FAIL rst_mid_zero%0d: got %b want 0", i,
                 {key_a, key_b, key_c, key_d, key_valid, key_code, key_err, busy});
      end
      step(1);
    end
    reset = 1'b1;
    step(7);
    total++;
    if ({key_d, key_valid, key_code} !== 4'b1111) begin
      bad++;
      $display("FAIL rst_mid_repulse: got %b want 1111", {key_d, key_valid, key_code});
    end
    raw_d = 1'b0;
    step(20);
    total++;
    if (ev_code.size() != 2 || ev_cyc[0] != c + 7 || ev_cyc[1] != c + 18 || ev_code[1] != 3) begin
      bad++;
      $display("FAIL rst_mid_events: got n=%0d want key D at cycles %0d and %0d", ev_code.size(), c + 7, c + 18);
    end
  endtask

  task automatic test_protocol;
    total++;
    if (proto_bad != 0) begin
      bad++;
      $display("FAIL protocol: got %0d bad cycles want 0", proto_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_sequence();
    test_simultaneous();
    test_press_during_hold();
    test_reset_mid_hold();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
